fp16_accum_seq: RTL and testbench
=================================

Name: fp16_accum_seq

Overview:
- Sums a stream of N FP16 values (1-5-10 format) using the shared 3-stage pipelined FP16 adder.
- The adder sits directly downstream of this block: this block drives its operand/enable inputs and consumes its result/ready outputs.
- Keeps ADD_LATENCY partial sums so the adder can accept one add per cycle, then reduces them to one result.
- Used by neuron evaluation to sum weighted inputs.

Parameters:
- ADD_LATENCY, 3, clock edges from add_en sampled high to add_ready high; also the number of partial-sum slots.
- COUNT_W, 8, width of the element count.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- start  input  1  one-cycle pulse; begins an accumulation. Ignored while busy.
- cfg_count  input  COUNT_W  number of elements N; sampled on start.
- in_data  input  16  FP16 element.
- in_valid  input  1  element present.
- in_ready  output  1  element accepted this cycle when in_valid and in_ready are both high.
- add_a  output  16  adder operand A (registered).
- add_b  output  16  adder operand B (registered).
- add_en  output  1  adder enable, one-cycle pulse per add (registered).
- add_result  input  16  adder sum.
- add_ready  input  1  adder result valid.
- sum_out  output  16  final sum; holds until the next result.
- sum_valid  output  1  one-cycle pulse when sum_out updates.
- busy  output  1  high from the cycle after start until the cycle after the sum_valid pulse.

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk.
  - All outputs reset to 0.
  - All slots reset to EMPTY; the tag delay line is cleared; the FSM returns to IDLE.
  - Reset mid-operation abandons the sum. Adder results still in flight are ignored because tag valids are cleared.
- Slots: ADD_LATENCY entries. Each holds a 16-bit value and a state EMPTY, LOADED or INFLIGHT.
- Tag delay line: ADD_LATENCY stages of {valid, slot index}, shifting every cycle. It is loaded in the same cycle add_en is registered high. Its head valid must coincide with add_ready.
- Writeback: on add_ready with the head tag valid, the tagged slot value becomes add_result and its state becomes LOADED at that edge. There is no bypass; the slot is usable the following cycle.
- add_ready with the head tag invalid is ignored.
- FSM states:
  - IDLE: on start, latch N and clear the accepted counter. N=0 goes to DONE with value 0x0000. Otherwise go to ACCUM.
  - ACCUM: in_ready = (accepted < N) and (some slot is EMPTY or LOADED). On acceptance:
    - If any slot is EMPTY, the lowest EMPTY slot takes in_data directly and becomes LOADED. No add is issued, because the adder has no exact zero.
    - Otherwise, for the lowest LOADED slot s: add_a = slot[s], add_b = in_data, add_en = 1, tag = s, and slot s becomes INFLIGHT.
    - When accepted reaches N, go to REDUCE.
  - REDUCE: in_ready = 0.
    - If no slot is INFLIGHT and exactly one slot is LOADED, go to DONE with that value.
    - If at least two slots are LOADED, and no add was issued last cycle, issue an add of the two lowest-index LOADED slots i<j. The result is tagged to i; i becomes INFLIGHT and j becomes EMPTY.
    - Otherwise wait.
  - DONE: sum_out = value, sum_valid pulses for one cycle, all slots are cleared to EMPTY, then go to IDLE.
- Arithmetic: values are passed through unmodified. Summation order is not preserved, which is acceptable.
- At most one add_en per cycle. add_en is never asserted in IDLE or DONE.
- Simultaneous writeback and acceptance in the same cycle: the acceptance uses pre-edge slot states.
- Simultaneous start and busy: start is ignored.
- in_valid outside ACCUM is ignored.
- Throughput: one element per cycle sustained once slots fill, with ADD_LATENCY=3 and no in_valid gaps.

Test Plan:
- N=4, four elements of 1.0 (0x3C00) back-to-back, with the adder attached:
  - in_ready is never deasserted.
  - Exactly 3 add_en pulses.
  - sum_out=0x4400, sum_valid pulses once.
- N=1, in_data=0x4500:
  - No add_en pulses.
  - sum_out=0x4500 two cycles after acceptance.
- N=0 start:
  - sum_out=0x0000 and sum_valid within 2 cycles.
  - in_ready stays low throughout.
- N=8 of 2.0 (0x4000) with in_valid toggling every other cycle, compared against a scoreboard:
  - sum_out=0x4C00 (16.0).
  - Never two add_en pulses in one cycle.
  - Every add_ready consumed exactly once.
- Reset asserted mid-ACCUM while 2 adds are in flight, then N=2 of 1.0 after reset:
  - Post-reset sum_out=0x4000.
  - The stale add_ready pulses do not corrupt any slot.
- start pulsed again while busy:
  - It is ignored, and the original sum completes unchanged.

Source files
------------

// File: rtl/fp16_accum_seq.sv
// Purpose: sums N FP16 elements through an external pipelined adder, keeping ADD_LATENCY partial-sum slots.
// Latency: the result pulses two cycles after the last slot settles (N=1: two cycles after acceptance; N=0: one cycle after start).
// Backpressure: in_ready drops when every slot is in flight or all N elements are taken; the adder has no backpressure.
module fp16_accum_seq #(
    parameter int ADD_LATENCY = 3,
    parameter int COUNT_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COUNT_W-1:0] cfg_count,
    input  logic [15:0]        in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [15:0]        add_a,
    output logic [15:0]        add_b,
    output logic               add_en,
    input  logic [15:0]        add_result,
    input  logic               add_ready,
    output logic [15:0]        sum_out,
    output logic               sum_valid,
    output logic               busy
);
    localparam int IDX_W = (ADD_LATENCY > 1) ? $clog2(ADD_LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, ACCUM, REDUCE, DONE} state_t;
    typedef enum logic [1:0] {EMPTY, LOADED, INFLIGHT} slot_t;

    state_t             state;
    logic [COUNT_W-1:0] count;
    logic [COUNT_W-1:0] accepted;
    logic [15:0]        doneVal;
    logic [15:0]        slotVal [ADD_LATENCY];
    slot_t              slotSt  [ADD_LATENCY];
    logic               tagVld  [ADD_LATENCY];
    logic [IDX_W-1:0]   tagIdx  [ADD_LATENCY];

    logic             haveEmpty;
    logic             haveLoaded;
    logic             twoLoaded;
    logic             anyInflight;
    logic [IDX_W-1:0] emptyIdx;
    logic [IDX_W-1:0] loIdx;
    logic [IDX_W-1:0] hiIdx;
    logic             accept;
    logic             accIssue;
    logic             reduceIssue;
    logic             reduceDone;
    logic             issue;
    logic             headHit;

    // Slot scan: lowest EMPTY, the two lowest LOADED, and whether anything is still in the adder.
    always_comb begin
        haveEmpty   = 1'b0;
        haveLoaded  = 1'b0;
        twoLoaded   = 1'b0;
        anyInflight = 1'b0;
        emptyIdx    = '0;
        loIdx       = '0;
        hiIdx       = '0;
        for (int i = 0; i < ADD_LATENCY; i++) begin
            if (slotSt[i] == EMPTY && !haveEmpty) begin
                haveEmpty = 1'b1;
                emptyIdx  = IDX_W'(i);
            end
            if (slotSt[i] == LOADED) begin
                if (!haveLoaded) begin
                    haveLoaded = 1'b1;
                    loIdx      = IDX_W'(i);
                end else if (!twoLoaded) begin
                    twoLoaded = 1'b1;
                    hiIdx     = IDX_W'(i);
                end
            end
            if (slotSt[i] == INFLIGHT) begin
                anyInflight = 1'b1;
            end
        end
    end

    // Handshake and issue decisions, all derived from pre-edge slot state.
    assign in_ready    = (state == ACCUM) && (accepted < count) && (haveEmpty || haveLoaded);
    assign accept      = in_valid && in_ready;
    assign accIssue    = accept && !haveEmpty;
    // Back-to-back reduction adds are spaced by one cycle so a pair is never issued behind a fresh issue.
    assign reduceIssue = (state == REDUCE) && twoLoaded && !add_en;
    assign reduceDone  = (state == REDUCE) && !anyInflight && haveLoaded && !twoLoaded;
    assign issue       = accIssue || reduceIssue;
    assign headHit     = add_ready && tagVld[ADD_LATENCY-1];

    // Tag delay line: loaded on the edge that raises add_en, so its head lines up with add_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ADD_LATENCY; i++) begin
                tagVld[i] <= 1'b0;
                tagIdx[i] <= '0;
            end
        end else begin
            tagVld[0] <= issue;
            tagIdx[0] <= loIdx;
            for (int i = 1; i < ADD_LATENCY; i++) begin
                tagVld[i] <= tagVld[i-1];
                tagIdx[i] <= tagIdx[i-1];
            end
        end
    end

    // Control FSM with slot writeback, operand registers and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            accepted  <= '0;
            doneVal   <= '0;
            add_a     <= '0;
            add_b     <= '0;
            add_en    <= 1'b0;
            sum_out   <= '0;
            sum_valid <= 1'b0;
            busy      <= 1'b0;
            for (int i = 0; i < ADD_LATENCY; i++) begin
                slotVal[i] <= '0;
                slotSt[i]  <= EMPTY;
            end
        end else begin
            add_en    <= 1'b0;
            sum_valid <= 1'b0;

            // Writeback only ever targets an INFLIGHT slot, so it never collides with the
            // EMPTY/LOADED slots touched by acceptance or reduction below.
            if (headHit) begin
                slotVal[tagIdx[ADD_LATENCY-1]] <= add_result;
                slotSt[tagIdx[ADD_LATENCY-1]]  <= LOADED;
            end

            case (state)
                IDLE: begin
                    // busy is still high in the cycle of the sum_valid pulse; a start there is dropped.
                    if (start && !busy) begin
                        count    <= cfg_count;
                        accepted <= '0;
                        busy     <= 1'b1;
                        if (cfg_count == '0) begin
                            doneVal <= '0;
                            state   <= DONE;
                        end else begin
                            state <= ACCUM;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        accepted <= accepted + 1'b1;
                        if (haveEmpty) begin
                            // The adder has no exact zero, so an empty slot is seeded rather than added to.
                            slotVal[emptyIdx] <= in_data;
                            slotSt[emptyIdx]  <= LOADED;
                        end else begin
                            add_a          <= slotVal[loIdx];
                            add_b          <= in_data;
                            add_en         <= 1'b1;
                            slotSt[loIdx]  <= INFLIGHT;
                        end
                        if (accepted + 1'b1 == count) begin
                            state <= REDUCE;
                        end
                    end
                end
                REDUCE: begin
                    if (reduceDone) begin
                        doneVal <= slotVal[loIdx];
                        state   <= DONE;
                    end else if (reduceIssue) begin
                        add_a         <= slotVal[loIdx];
                        add_b         <= slotVal[hiIdx];
                        add_en        <= 1'b1;
                        slotSt[loIdx] <= INFLIGHT;
                        slotSt[hiIdx] <= EMPTY;
                    end
                end
                DONE: begin
                    sum_out   <= doneVal;
                    sum_valid <= 1'b1;
                    for (int i = 0; i < ADD_LATENCY; i++) begin
                        slotSt[i] <= EMPTY;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp16_accum_seq.sv
// Directed bench for fp16_accum_seq with a behavioural pipelined FP16 adder attached.
// Expected sums go into a scoreboard queue at start and are checked when sum_valid pulses.
module tb_fp16_accum_seq;
    localparam int ADD_LATENCY = 3;
    localparam int COUNT_W     = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [COUNT_W-1:0] cfg_count;
    logic [15:0]        in_data;
    logic               in_valid;
    logic               in_ready;
    logic [15:0]        add_a;
    logic [15:0]        add_b;
    logic               add_en;
    logic [15:0]        add_result;
    logic               add_ready;
    logic [15:0]        sum_out;
    logic               sum_valid;
    logic               busy;

    fp16_accum_seq #(.ADD_LATENCY(ADD_LATENCY), .COUNT_W(COUNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cfg_count  (cfg_count),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_en     (add_en),
        .add_result (add_result),
        .add_ready  (add_ready),
        .sum_out    (sum_out),
        .sum_valid  (sum_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Positive FP16 <-> real conversion, enough for the exact small values used here.
    function automatic real h2r(input logic [15:0] h);
        real m;
        int  e;
        e = int'(h[14:10]);
        m = (e == 0) ? real'(h[9:0]) / 1024.0 : 1.0 + real'(h[9:0]) / 1024.0;
        if (e == 0) e = 1;
        for (int k = 0; k < 15 - e; k++) m = m / 2.0;
        for (int k = 0; k < e - 15; k++) m = m * 2.0;
        return m;
    endfunction

    function automatic logic [15:0] r2h(input real r);
        int         e;
        int         man;
        logic [4:0] eb;
        logic [9:0] mb;
        if (r <= 0.0) return 16'h0000;
        e = 15;
        while (r >= 2.0) begin r = r / 2.0; e++; end
        while (r < 1.0)  begin r = r * 2.0; e--; end
        man = int'((r - 1.0) * 1024.0);
        eb  = 5'(e);
        mb  = 10'(man);
        return {1'b0, eb, mb};
    endfunction

    // Adder model: not tied to rst, so in-flight results keep coming out after a DUT reset.
    // add_ready rises ADD_LATENCY edges after (and counting) the edge that raises add_en.
    logic [15:0] pipeSum1 = 16'h0;
    logic [15:0] pipeSum2 = 16'h0;
    logic        pipeVld1 = 1'b0;
    logic        pipeVld2 = 1'b0;
    always @(posedge clk) begin
        pipeVld1 <= add_en;
        pipeSum1 <= r2h(h2r(add_a) + h2r(add_b));
        pipeVld2 <= pipeVld1;
        pipeSum2 <= pipeSum1;
    end
    assign add_ready  = pipeVld2;
    assign add_result = pipeSum2;

    int          tests = 0;
    int          fails = 0;
    int          addEnCnt = 0;
    int          addRdyCnt = 0;
    int          sumCnt = 0;
    int          stallCnt = 0;
    logic [15:0] expQ [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and observe the cycle's outputs.
    task automatic tick();
        @(negedge clk);
        if (add_en) addEnCnt++;
        if (add_ready) addRdyCnt++;
        if (sum_valid) begin
            sumCnt++;
            if (expQ.size() == 0) check("sum_unexpected", 32'(sum_valid), 32'(0));
            else check("sum_scoreboard", 32'(sum_out), 32'(expQ.pop_front()));
        end
    endtask

    task automatic doStart(input logic [7:0] n, input bit push, input logic [15:0] expVal);
        start     = 1'b1;
        cfg_count = n;
        if (push) expQ.push_back(expVal);
        tick();
        start = 1'b0;
    endtask

    task automatic sendElem(input logic [15:0] data);
        bit got;
        got      = 1'b0;
        in_valid = 1'b1;
        in_data  = data;
        for (int c = 0; c < 100 && !got; c++) begin
            if (in_ready) got = 1'b1;
            else stallCnt++;
            tick();
        end
        in_valid = 1'b0;
        if (!got) check("accept_timeout", 32'(got), 32'(1));
    endtask

    task automatic waitIdle(input string tag, input int budget);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (!busy && expQ.size() == 0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check(tag, 32'(ok), 32'(1));
    endtask

    int e0;
    int r0;
    int s0;
    bit seen;

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        cfg_count = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        repeat (3) @(negedge clk);
        check("rst_sum_out",   32'(sum_out),   32'(0));
        check("rst_sum_valid", 32'(sum_valid), 32'(0));
        check("rst_busy",      32'(busy),      32'(0));
        check("rst_add_en",    32'(add_en),    32'(0));
        check("rst_add_a",     32'(add_a),     32'(0));
        check("rst_add_b",     32'(add_b),     32'(0));
        check("rst_in_ready",  32'(in_ready),  32'(0));
        rst = 1'b0;
        tick();

        // N=4 of 1.0 back-to-back: no stalls, three adds, 4.0.
        e0 = addEnCnt; r0 = addRdyCnt; s0 = sumCnt; stallCnt = 0;
        doStart(8'd4, 1'b1, 16'h4400);
        check("t1_busy", 32'(busy), 32'(1));
        for (int i = 0; i < 4; i++) sendElem(16'h3C00);
        waitIdle("t1_done", 100);
        check("t1_stalls",    32'(stallCnt),          32'(0));
        check("t1_add_en",    32'(addEnCnt - e0),     32'(3));
        check("t1_add_ready", 32'(addRdyCnt - r0),    32'(3));
        check("t1_pulses",    32'(sumCnt - s0),       32'(1));
        check("t1_hold",      32'(sum_out),           32'(16'h4400));

        // N=1: value passes straight through, result two cycles after acceptance.
        e0 = addEnCnt;
        doStart(8'd1, 1'b1, 16'h4500);
        sendElem(16'h4500);
        check("t2_valid_c0", 32'(sum_valid), 32'(0));
        tick();
        check("t2_valid_c1", 32'(sum_valid), 32'(0));
        tick();
        check("t2_valid_c2", 32'(sum_valid), 32'(1));
        check("t2_sum_out",  32'(sum_out),   32'(16'h4500));
        waitIdle("t2_done", 20);
        check("t2_add_en", 32'(addEnCnt - e0), 32'(0));

        // N=0: immediate zero result, never ready for data.
        doStart(8'd0, 1'b1, 16'h0000);
        check("t3_in_ready_c0", 32'(in_ready), 32'(0));
        tick();
        check("t3_sum_valid", 32'(sum_valid), 32'(1));
        check("t3_sum_out",   32'(sum_out),   32'(0));
        check("t3_in_ready_c1", 32'(in_ready), 32'(0));
        waitIdle("t3_done", 10);

        // N=8 of 2.0 with in_valid toggling: 16.0, seven adds, every result consumed.
        e0 = addEnCnt; r0 = addRdyCnt; s0 = sumCnt;
        doStart(8'd8, 1'b1, 16'h4C00);
        for (int i = 0; i < 8; i++) begin
            sendElem(16'h4000);
            tick();
        end
        waitIdle("t4_done", 200);
        check("t4_add_en",    32'(addEnCnt - e0),  32'(7));
        check("t4_add_ready", 32'(addRdyCnt - r0), 32'(7));
        check("t4_pulses",    32'(sumCnt - s0),    32'(1));

        // Reset with two adds in flight, then N=2 of 1.0 while stale results drain out.
        e0 = addEnCnt;
        doStart(8'd8, 1'b0, 16'h0000);
        for (int i = 0; i < 5; i++) sendElem(16'h3C00);
        check("t5_inflight", 32'(addEnCnt - e0), 32'(2));
        rst = 1'b1;
        tick();
        check("t5_rst_busy",   32'(busy),   32'(0));
        check("t5_rst_add_en", 32'(add_en), 32'(0));
        rst = 1'b0;
        s0 = sumCnt;
        doStart(8'd2, 1'b1, 16'h4000);
        sendElem(16'h3C00);
        sendElem(16'h3C00);
        waitIdle("t5_done", 100);
        check("t5_pulses", 32'(sumCnt - s0), 32'(1));
        check("t5_sum_out", 32'(sum_out), 32'(16'h4000));

        // start while busy: mid-stream and in the sum_valid cycle, both ignored.
        s0 = sumCnt;
        doStart(8'd4, 1'b1, 16'h4400);
        sendElem(16'h3C00);
        sendElem(16'h3C00);
        doStart(8'd1, 1'b0, 16'h0000);
        sendElem(16'h3C00);
        sendElem(16'h3C00);
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (sum_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("t6_sum_seen", 32'(seen), 32'(1));
        doStart(8'd0, 1'b0, 16'h0000);
        repeat (6) tick();
        check("t6_pulses",   32'(sumCnt - s0), 32'(1));
        check("t6_busy",     32'(busy),        32'(0));
        check("t6_sum_out",  32'(sum_out),     32'(16'h4400));
        check("t6_queue",    32'(expQ.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
